pmem_loader: RTL

PMEM_LOADER -- requirements
Module: pmem_loader

---
 rtl/pmem_loader.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/pmem_loader.sv
// rtl/pmem_loader.sv - byte-stream program-memory loader; optional checksum via PMEM_LOADER_CHECKSUM_EN
module pmem_loader #(
    parameter int PMEM_ADDR_WIDTH = 12,
    parameter int PMEM_WORD_WIDTH = 16,
    parameter int PMEM_NUM_WORDS  = 2048,
    parameter int PC_INCREMENT    = 2
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       in_start,
    input  logic                       in_byte_valid,
    input  logic [7:0]                 in_byte,
    output logic                       out_byte_ready,
    output logic [PMEM_ADDR_WIDTH-1:0] out_pmem_wr_addr,
    output logic [PMEM_WORD_WIDTH-1:0] out_pmem_wr_word,
    output logic                       out_pmem_write_en,
    output logic                       out_core_reset,
    output logic                       out_busy,
    output logic                       out_done,
    output logic                       out_error
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LEN_HI  = 3'd1,
        S_LEN_LO  = 3'd2,
        S_DATA_HI = 3'd3,
        S_DATA_LO = 3'd4,
`ifdef PMEM_LOADER_CHECKSUM_EN
        S_CHECK   = 3'd5,
`endif
        S_DONE    = 3'd6,
        S_ERROR   = 3'd7
    } state_t;

    // State entered once the last word (or an empty length) has been taken
`ifdef PMEM_LOADER_CHECKSUM_EN
    localparam state_t S_FINISH = S_CHECK;
`else
    localparam state_t S_FINISH = S_DONE;
`endif

    localparam logic [16:0]                MAX_WORDS = 17'(PMEM_NUM_WORDS);
    localparam logic [PMEM_ADDR_WIDTH-1:0] ADDR_STEP = PMEM_ADDR_WIDTH'(PC_INCREMENT);

    state_t                     state_q, state_d;
    logic [PMEM_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [7:0]                 len_hi_q, len_hi_d;
    logic [15:0]                remaining_q, remaining_d;
    logic [7:0]                 hi_q, hi_d;
    logic                       wr_en_q, wr_en_d;
    logic [PMEM_ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [PMEM_WORD_WIDTH-1:0] wr_word_q, wr_word_d;
`ifdef PMEM_LOADER_CHECKSUM_EN
    logic [7:0]                 sum_q, sum_d;
`endif

    logic        byte_ready;
    logic        xfer;
    logic [15:0] len_word;

    assign byte_ready = (state_q == S_LEN_HI) || (state_q == S_LEN_LO) ||
                        (state_q == S_DATA_HI) || (state_q == S_DATA_LO)
`ifdef PMEM_LOADER_CHECKSUM_EN
                        || (state_q == S_CHECK)
`endif
                        ;
    assign xfer     = in_byte_valid && byte_ready;
    assign len_word = {len_hi_q, in_byte};

    // Register all state; reset also kills any write strobe about to issue
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            len_hi_q    <= '0;
            remaining_q <= '0;
            hi_q        <= '0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_word_q   <= '0;
`ifdef PMEM_LOADER_CHECKSUM_EN
            sum_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            len_hi_q    <= len_hi_d;
            remaining_q <= remaining_d;
            hi_q        <= hi_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_word_q   <= wr_word_d;
`ifdef PMEM_LOADER_CHECKSUM_EN
            sum_q       <= sum_d;
`endif
        end
    end

    // Next-state: one state step per accepted byte, write staged on the low data byte
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        len_hi_d    = len_hi_q;
        remaining_d = remaining_q;
        hi_d        = hi_q;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_word_d   = wr_word_q;
`ifdef PMEM_LOADER_CHECKSUM_EN
        sum_d       = sum_q;
`endif
        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (in_start) begin
                    state_d     = S_LEN_HI;
                    addr_d      = '0;
                    len_hi_d    = '0;
                    remaining_d = '0;
`ifdef PMEM_LOADER_CHECKSUM_EN
                    sum_d       = '0;
`endif
                end
            end
            S_LEN_HI: begin
                if (xfer) begin
                    len_hi_d = in_byte;
                    state_d  = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                if (xfer) begin
                    remaining_d = len_word;
                    if (len_word == 16'd0) begin
                        state_d = S_FINISH;
                    end else if ({1'b0, len_word} > MAX_WORDS) begin
                        state_d = S_ERROR;
                    end else begin
                        state_d = S_DATA_HI;
                    end
                end
            end
            S_DATA_HI: begin
                if (xfer) begin
                    hi_d    = in_byte;
                    state_d = S_DATA_LO;
`ifdef PMEM_LOADER_CHECKSUM_EN
                    sum_d   = sum_q + in_byte;
`endif
                end
            end
            S_DATA_LO: begin
                if (xfer) begin
                    wr_en_d     = 1'b1;
                    wr_addr_d   = addr_q;
                    wr_word_d   = {hi_q, in_byte};
                    addr_d      = addr_q + ADDR_STEP;
                    remaining_d = remaining_q - 16'd1;
                    state_d     = (remaining_q == 16'd1) ? S_FINISH : S_DATA_HI;
`ifdef PMEM_LOADER_CHECKSUM_EN
                    sum_d       = sum_q + in_byte;
`endif
                end
            end
`ifdef PMEM_LOADER_CHECKSUM_EN
            S_CHECK: begin
                if (xfer) begin
                    state_d = (8'(sum_q + in_byte) == 8'd0) ? S_DONE : S_ERROR;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs decoded from state; done waits until the final strobe has gone out
    always_comb begin
        out_byte_ready    = byte_ready;
        out_busy          = byte_ready;
        out_done          = (state_q == S_DONE) && !wr_en_q;
        out_error         = (state_q == S_ERROR);
        out_core_reset    = !((state_q == S_DONE) && !wr_en_q);
        out_pmem_write_en = wr_en_q;
        out_pmem_wr_addr  = wr_addr_q;
        out_pmem_wr_word  = wr_word_q;
    end

endmodule
